fetch_pc_gen: RTL and testbench
===============================

// Module: fetch_pc_gen
// PURPOSE
//   Parametrised next-PC generator for the IF stage. Holds the fetch PC and supports
//   stall and execute-stage redirect. With the optional direct-mapped BTB compiled in,
//   it also predicts taken branches and jumps.
//   Sits between the execute redirect path and the IMEM/BIOS fetch address.
// PARAMETERS
//   XLEN        32             width of PC and target buses
//   RESET_PC    32'h4000_0000  PC presented after reset (BIOS base)
//   BTB_ENTRIES 16             BTB depth; power of two, >=2; IDX = log2(BTB_ENTRIES)
// PORTS
//   clk            in   1     core clock; all state on posedge
//   rst            in   1     synchronous reset, active-high
//   stall          in   1     hold PC (downstream not ready)
//   redirect_valid in   1     execute-stage override (mispredict / jump / trap)
//   redirect_pc    in   XLEN  override target; bits[1:0] ignored, forced 0
//   btb_upd_valid  in   1     BTB write request from execute
//   btb_upd_pc     in   XLEN  PC of the resolved control-flow instruction
//   btb_upd_target in   XLEN  resolved target; bits[1:0] forced 0
//   btb_upd_taken  in   1     1 = install/overwrite entry, 0 = invalidate on tag match
//   pc             out  XLEN  current fetch PC
//   fetch_valid    out  1     pc is a real fetch (0 in the first cycle out of reset)
//   pred_taken     out  1     BTB hit on pc; next pc is pred_target
//   pred_target    out  XLEN  predicted target (0 when pred_taken=0)
// BEHAVIOUR
//   - Reset (any cycle, incl. mid-redirect or mid-update): pc<=RESET_PC, fetch_valid<=0,
//     all BTB valid bits<=0. btb_upd_* and redirect_* are ignored while rst=1.
//   - First edge after rst falls: fetch_valid<=1, pc held at RESET_PC.
//     RESET_PC is therefore presented exactly once with fetch_valid=1.
//   - Next-PC priority at each edge (rst=0, fetch_valid=1):
//       redirect_valid > stall > pred_taken > sequential.
//     redirect:   pc<=redirect_pc & ~3, even when stall=1.
//     stall:      pc held.
//     pred_taken: pc<=pred_target.
//     else:       pc<=pc+4.
//   - Arithmetic: pc+4 is modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000); no overflow flag.
//   - Single-cycle latency: a redirect at edge N makes pc=redirect_pc visible after edge N.
//   - BTB organisation: index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
//     Each entry holds {valid, tag, target}.
//   - Lookup: combinational on current pc. hit = valid & tag match.
//     pred_taken = hit & fetch_valid.
//   - Update at posedge:
//     taken=1: writes {1, tag, target} unconditionally, overwriting any alias.
//     taken=0: clears valid only if the stored tag matches.
//   - Same-cycle lookup and update of one entry: lookup sees pre-write contents;
//     the new entry is visible next cycle.
//   - Simultaneous redirect and pred_taken: redirect wins, prediction is discarded.
//     Same-cycle BTB update still commits.
//   - No FSM beyond the fetch_valid reset flag.
// CONFIGURATION
//   FETCH_PC_GEN_BTB_EN defined:
//     BTB array, lookup and update logic are instantiated as described above.
//   FETCH_PC_GEN_BTB_EN undefined:
//     No BTB storage. pred_taken=0 and pred_target=0 constantly; btb_upd_* ignored.
//     Next PC is only redirect / stall / pc+4.
// TESTING
//   1. rst=1 for 2 cycles, then 0 -> pc=0x4000_0000 with fetch_valid=0, then
//      fetch_valid=1 at 0x4000_0000, then 0x4000_0004, 0x4000_0008.
//   2. stall=1 for 3 cycles at pc=0x4000_0010 -> pc holds 0x4000_0010,
//      then 0x4000_0014 after stall drops.
//   3. stall=1 and redirect_valid=1 with redirect_pc=0x1000_0203 in the same cycle ->
//      next pc=0x1000_0200.
//   4. BTB install pc=0x4000_0008, target=0x4000_0100; re-run from reset ->
//      at pc=0x4000_0008 pred_taken=1, next pc=0x4000_0100.
//      Then invalidate (taken=0) -> sequential 0x4000_000C.
//   5. Alias test: install 0x4000_0008 then 0x4000_0048 (BTB_ENTRIES=16, same index) ->
//      0x4000_0008 misses, 0x4000_0048 hits.
//   6. redirect to 0xFFFF_FFFC -> next pc 0x0000_0000.
//      rst asserted mid-stream -> BTB cleared (no hit on revisit).
//      Macro off -> pred_taken stays 0 throughout.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC generator for the IF stage.
// Holds the fetch PC and handles stall and execute-stage redirect.
// Optional feature macro: FETCH_PC_GEN_BTB_EN adds a direct-mapped BTB that
// predicts taken branches/jumps on the current fetch PC. Without it the next
// PC is only redirect / stall / pc+4.
module fetch_pc_gen #(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = XLEN'(32'h4000_0000),
  parameter int               BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            btb_upd_valid,
  input  logic [XLEN-1:0] btb_upd_pc,
  input  logic [XLEN-1:0] btb_upd_target,
  input  logic            btb_upd_taken,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            pred_taken_w;
  logic [XLEN-1:0] pred_target_w;

`ifdef FETCH_PC_GEN_BTB_EN
  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]        tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];

  logic [IDX-1:0]  look_idx, upd_idx;
  logic [TAGW-1:0] look_tag, upd_tag;
  logic            hit;
  logic            unused_btb;

  assign look_idx = pc_q[IDX+1:2];
  assign look_tag = pc_q[XLEN-1:IDX+2];
  assign upd_idx  = btb_upd_pc[IDX+1:2];
  assign upd_tag  = btb_upd_pc[XLEN-1:IDX+2];

  // Lookup reads the array before any same-edge write, so a fresh entry
  // only becomes visible the cycle after it is written.
  assign hit           = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign pred_taken_w  = hit && fetch_valid_q;
  assign pred_target_w = pred_taken_w ? target_q[look_idx] : '0;

  assign unused_btb = ^{btb_upd_pc[1:0], btb_upd_target[1:0]};

  // Valid bits: cleared by reset, set on install, cleared by a tag-matching invalidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (btb_upd_valid) begin
      if (btb_upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
      end else if (tag_q[upd_idx] == upd_tag) begin
        valid_q[upd_idx] <= 1'b0;
      end
    end
  end

  // Tag/target payload: only meaningful behind a valid bit, so no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && btb_upd_valid && btb_upd_taken) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= btb_upd_target & WORD_MASK;
    end
  end
`else
  logic unused_btb;
  logic unused_cfg;

  assign pred_taken_w  = 1'b0;
  assign pred_target_w = '0;
  assign unused_btb    = ^{btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken};
  assign unused_cfg    = (BTB_ENTRIES > 1);
`endif

  // Next-PC selection: redirect beats stall beats prediction beats sequential.
  always_comb begin
    pc_d          = pc_q;
    fetch_valid_d = 1'b1;
    if (!fetch_valid_q) begin
      pc_d = pc_q;
    end else if (redirect_valid) begin
      pc_d = redirect_pc & WORD_MASK;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken_w) begin
      pc_d = pred_target_w;
    end else begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  // PC and fetch_valid registers; fetch_valid is the only post-reset state flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign pred_taken  = pred_taken_w;
  assign pred_target = pred_target_w;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: scoreboard bench for fetch_pc_gen.
// Each step drives one cycle of inputs, queues the outputs expected after the
// edge, then pops and compares them once the edge has passed.
module tb_fetch_pc_gen;

`ifdef FETCH_PC_GEN_BTB_EN
  localparam bit BtbOn = 1'b1;
`else
  localparam bit BtbOn = 1'b0;
`endif

  localparam logic [31:0] R = 32'h4000_0000;

  typedef struct {
    int          step;
    logic [31:0] pc;
    logic        fv;
    logic        pt;
    logic [31:0] tgt;
  } expect_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        btb_upd_valid;
  logic [31:0] btb_upd_pc;
  logic [31:0] btb_upd_target;
  logic        btb_upd_taken;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        pred_taken;
  logic [31:0] pred_target;

  expect_t scoreboard[$];
  int      checkCount;
  int      passCount;

  fetch_pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .btb_upd_valid  (btb_upd_valid),
    .btb_upd_pc     (btb_upd_pc),
    .btb_upd_target (btb_upd_target),
    .btb_upd_taken  (btb_upd_taken),
    .pc             (pc),
    .fetch_valid    (fetch_valid),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One cycle: drive inputs on the falling edge, queue the post-edge outputs,
  // then compare them 1 ns after the rising edge.
  task automatic applyStimulus(
    input int          n,
    input logic        r,
    input logic        st,
    input logic        rv,
    input logic [31:0] rpc,
    input logic        uv,
    input logic [31:0] upc,
    input logic [31:0] utgt,
    input logic        utk,
    input logic [31:0] ePc,
    input logic        eFv,
    input logic        ePt,
    input logic [31:0] eTgt
  );
    expect_t e;
    expect_t got;
    @(negedge clk);
    rst            = r;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    btb_upd_valid  = uv;
    btb_upd_pc     = upc;
    btb_upd_target = utgt;
    btb_upd_taken  = utk;
    e.step = n;
    e.pc   = ePc;
    e.fv   = eFv;
    e.pt   = ePt;
    e.tgt  = eTgt;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    if (scoreboard.size() == 0) begin
      checkOutput($sformatf("s%0d.queue", n), 32'd0, 32'd1);
    end else begin
      got = scoreboard.pop_front();
      checkOutput($sformatf("s%0d.pc", got.step), pc, got.pc);
      checkOutput($sformatf("s%0d.fetch_valid", got.step), {31'd0, fetch_valid}, {31'd0, got.fv});
      checkOutput($sformatf("s%0d.pred_taken", got.step), {31'd0, pred_taken}, {31'd0, got.pt});
      checkOutput($sformatf("s%0d.pred_target", got.step), pred_target, got.tgt);
    end
  endtask

  // Plain cycle with no redirect/update: only the expected outputs vary.
  task automatic seqStep(input int n, input logic st, input logic [31:0] ePc, input logic ePt, input logic [31:0] eTgt);
    applyStimulus(n, 1'b0, st, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, ePc, 1'b1, ePt, eTgt);
  endtask

  task automatic redirStep(input int n, input logic [31:0] rpc, input logic [31:0] ePc, input logic ePt, input logic [31:0] eTgt);
    applyStimulus(n, 1'b0, 1'b0, 1'b1, rpc, 1'b0, 32'h0, 32'h0, 1'b0, ePc, 1'b1, ePt, eTgt);
  endtask

  initial begin
    checkCount     = 0;
    passCount      = 0;
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    btb_upd_valid  = 1'b0;
    btb_upd_pc     = 32'h0;
    btb_upd_target = 32'h0;
    btb_upd_taken  = 1'b0;

    // Reset for two cycles, then RESET_PC once with fetch_valid, then sequential.
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, R, 1'b0, 1'b0, 32'h0);
    applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, R, 1'b0, 1'b0, 32'h0);
    seqStep(3, 1'b0, R, 1'b0, 32'h0);
    seqStep(4, 1'b0, 32'h4000_0004, 1'b0, 32'h0);
    seqStep(5, 1'b0, 32'h4000_0008, 1'b0, 32'h0);

    // Stall holds the PC for three cycles.
    redirStep(6, 32'h4000_0010, 32'h4000_0010, 1'b0, 32'h0);
    seqStep(7, 1'b1, 32'h4000_0010, 1'b0, 32'h0);
    seqStep(8, 1'b1, 32'h4000_0010, 1'b0, 32'h0);
    seqStep(9, 1'b1, 32'h4000_0010, 1'b0, 32'h0);
    seqStep(10, 1'b0, 32'h4000_0014, 1'b0, 32'h0);

    // Redirect beats stall and low bits are cleared.
    applyStimulus(11, 1'b0, 1'b1, 1'b1, 32'h1000_0203, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1000_0200, 1'b1, 1'b0, 32'h0);
    seqStep(12, 1'b0, 32'h1000_0204, 1'b0, 32'h0);

    // Install 0x4000_0008 -> 0x4000_0101 (stored word-aligned), then walk into it.
    applyStimulus(13, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4000_0008, 32'h4000_0101, 1'b1, 32'h1000_0208, 1'b1, 1'b0, 32'h0);
    redirStep(14, R, R, 1'b0, 32'h0);
    seqStep(15, 1'b0, 32'h4000_0004, 1'b0, 32'h0);
    seqStep(16, 1'b0, 32'h4000_0008, BtbOn, BtbOn ? 32'h4000_0100 : 32'h0);
    seqStep(17, 1'b0, BtbOn ? 32'h4000_0100 : 32'h4000_000C, 1'b0, 32'h0);

    // Invalidate with matching tag, then fetch is sequential.
    applyStimulus(18, 1'b0, 1'b0, 1'b1, 32'h4000_0008, 1'b1, 32'h4000_0008, 32'h0, 1'b0, 32'h4000_0008, 1'b1, 1'b0, 32'h0);
    seqStep(19, 1'b0, 32'h4000_000C, 1'b0, 32'h0);

    // Reinstall, then redirect over an active prediction while installing an alias.
    applyStimulus(20, 1'b0, 1'b0, 1'b1, 32'h4000_0008, 1'b1, 32'h4000_0008, 32'h4000_0100, 1'b1, 32'h4000_0008, 1'b1, BtbOn, BtbOn ? 32'h4000_0100 : 32'h0);
    applyStimulus(21, 1'b0, 1'b0, 1'b1, 32'h4000_0200, 1'b1, 32'h4000_0048, 32'h4000_0300, 1'b1, 32'h4000_0200, 1'b1, 1'b0, 32'h0);
    redirStep(22, 32'h4000_0008, 32'h4000_0008, 1'b0, 32'h0);
    seqStep(23, 1'b0, 32'h4000_000C, 1'b0, 32'h0);
    redirStep(24, 32'h4000_0048, 32'h4000_0048, BtbOn, BtbOn ? 32'h4000_0300 : 32'h0);
    seqStep(25, 1'b0, BtbOn ? 32'h4000_0300 : 32'h4000_004C, 1'b0, 32'h0);

    // Invalidate with a non-matching tag leaves the aliased entry alive.
    applyStimulus(26, 1'b0, 1'b0, 1'b1, 32'h4000_0048, 1'b1, 32'h4000_0008, 32'h0, 1'b0, 32'h4000_0048, 1'b1, BtbOn, BtbOn ? 32'h4000_0300 : 32'h0);

    // Sequential wrap past the top of the address space.
    redirStep(27, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0);
    seqStep(28, 1'b0, 32'h0000_0000, 1'b0, 32'h0);
    seqStep(29, 1'b0, 32'h0000_0004, 1'b0, 32'h0);

    // Mid-stream reset ignores redirect/update and clears the BTB.
    applyStimulus(30, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h4000_0000, 32'h5000_0000, 1'b1, R, 1'b0, 1'b0, 32'h0);
    seqStep(31, 1'b0, R, 1'b0, 32'h0);
    seqStep(32, 1'b0, 32'h4000_0004, 1'b0, 32'h0);
    redirStep(33, 32'h4000_0048, 32'h4000_0048, 1'b0, 32'h0);
    seqStep(34, 1'b0, 32'h4000_004C, 1'b0, 32'h0);

    // Install for the current PC: lookup sees old contents this cycle.
    applyStimulus(35, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4000_004C, 32'h4000_0500, 1'b1, 32'h4000_0050, 1'b1, 1'b0, 32'h0);
    redirStep(36, 32'h4000_004C, 32'h4000_004C, BtbOn, BtbOn ? 32'h4000_0500 : 32'h0);
    seqStep(37, 1'b0, BtbOn ? 32'h4000_0500 : 32'h4000_0050, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
